stepdir_position_tracker: RTL and testbench
===========================================

# stepdir_position_tracker

Receive-side counterpart of the CoreXY step/dir generator: samples the two motor step/dir pairs, filters and counts qualified step pulses into signed motor positions, and derives CoreXY X/Y positions from them. Sits on the step/dir pins (loopback or tap) to provide closed-loop position readback and protocol checking for the motion path; flags direction-setup violations.

## Interface
- SYNC_STAGES, 2, synchronizer depth on step/dir inputs (≥2)
- MIN_HIGH, 2, consecutive synchronized high cycles needed to qualify a step (≥1)
- DIR_SETUP, 4, minimum cycles dir must be stable before a step rising edge (≥1)

- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- step_1  in  1  motor 1 step pulse (asynchronous to clk)
- dir_1  in  1  motor 1 direction; 0 = +1 per step, 1 = −1 per step
- step_2  in  1  motor 2 step pulse
- dir_2  in  1  motor 2 direction, same encoding
- clear  in  1  synchronous: zero all position counters
- err_clear  in  1  synchronous: clear dir_err
- pos_1  out  32  motor 1 position, two's complement
- pos_2  out  32  motor 2 position, two's complement
- pos_x  out  33  pos_1 + pos_2 (doubled X units), two's complement
- pos_y  out  33  pos_1 − pos_2 (doubled Y units), two's complement
- step_evt_1  out  1  one-cycle strobe: motor 1 step counted
- step_evt_2  out  1  one-cycle strobe: motor 2 step counted
- dir_err  out  1  sticky: dir setup/hold violation on either channel

## Operation
- Each of step_1, dir_1, step_2, dir_2 passes an SYNC_STAGES flop chain (reset 0); only synchronized values (s_step, s_dir) used below.
- Per-channel FSM, reset IDLE:
  - IDLE: s_step=0. On s_step=1 → QUAL, qual counter=1, latch s_dir as step direction, perform setup check.
  - QUAL: s_step=1 increments counter; when counter reaches MIN_HIGH → COUNTED and count the step. s_step=0 before that → IDLE, no count (glitch rejected).
  - COUNTED: wait for s_step=0 → IDLE. Exactly one count per qualified pulse regardless of high width.
  - MIN_HIGH=1: count on the IDLE→QUAL detection cycle directly into COUNTED.
- Counting: pos_n += 1 if latched dir=0, −= 1 if 1; modulo 2^32 (wrap, no saturation).
- pos_x/pos_y: registered, updated on the same edge as pos_1/pos_2; always equal sign-extended pos_1±pos_2 of the current values. Both channels stepping same cycle: pos_x changes by ±2 or 0, pos_y likewise.
- Dir check: per-channel counter of cycles since last s_dir change, saturating at DIR_SETUP, reset to DIR_SETUP. Set dir_err if a rising s_step is detected with counter < DIR_SETUP, or if s_dir changes while FSM in QUAL or COUNTED.
- clear: zeroes pos_1, pos_2, pos_x, pos_y; wins over a step counted in the same cycle (that step dropped, step_evt still pulses). FSMs, synchronizers, dir_err unaffected.
- err_clear: clears dir_err; a new violation in the same cycle wins (dir_err stays 1).

## Timing
- Reset (rst_n=0, async): all outputs 0, FSMs IDLE, sync chains 0, dir counters = DIR_SETUP (first step after reset never flagged).
- Latency: input step rising edge captured at edge k → pos_n and step_evt_n update at edge k + SYNC_STAGES + MIN_HIGH − 1; step_evt high exactly one cycle.
- Minimum accepted pulse: high ≥ MIN_HIGH cycles, low ≥ 1 cycle (+1 cycle synchronizer uncertainty); generator step periods of speed ≥ MIN_HIGH+1 cycles per half-period count exactly.
- Reset mid-pulse: counts nothing for that pulse; a pulse still high when rst_n deasserts is counted once after qualifying (synchronizer reloads from 0).
- No backpressure; outputs valid every cycle.

## Test plan
- Reset, then 10 pulses on step_1 with dir_1=0, high/low 5 cycles each → pos_1=10, pos_2=0, pos_x=10, pos_y=10, 10 step_evt_1 strobes, dir_err=0.
- Both channels 7 simultaneous pulses, dir_1=0, dir_2=1 → pos_1=7, pos_2=−7 (0xFFFFFFF9), pos_x=0, pos_y=14.
- 1-cycle glitch on step_2 (MIN_HIGH=2) → no count, no strobe; following 3-cycle pulse → pos_2=1.
- pos_1 preloaded to 0x7FFFFFFF via 2^31−1 steps (or forced), one more +step → pos_1=0x80000000, pos_x sign-extended = −2^31 + pos_2.
- dir_1 toggled 2 cycles before step_1 rise → dir_err=1 and step still counted; err_clear → 0; err_clear coincident with new violation → stays 1.
- clear asserted on the step_evt_1 cycle → all positions 0; rst_n asserted mid-pulse → outputs 0 immediately.

Source files
------------

// File: rtl/stepdir_position_tracker.sv
// Step/dir receiver: synchronizes two motor step/dir pairs, qualifies step pulses,
// tracks signed motor positions and derived CoreXY X/Y, and flags dir timing violations.
module stepdir_position_tracker #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HIGH    = 2,
  parameter int DIR_SETUP   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step_1,
  input  logic        dir_1,
  input  logic        step_2,
  input  logic        dir_2,
  input  logic        clear,
  input  logic        err_clear,
  output logic [31:0] pos_1,
  output logic [31:0] pos_2,
  output logic [32:0] pos_x,
  output logic [32:0] pos_y,
  output logic        step_evt_1,
  output logic        step_evt_2,
  output logic        dir_err
);

  typedef enum logic [1:0] {IDLE, QUAL, COUNTED} state_t;

  localparam int QW = $clog2(MIN_HIGH + 1);
  localparam int DW = $clog2(DIR_SETUP + 1);

  // Bit order per stage: {dir_2, step_2, dir_1, step_1}.
  logic [3:0] sync_q [SYNC_STAGES];
  logic [1:0] s_step, s_dir;
  logic [1:0] evt, neg, viol;

  // NOTE: the synchronizer is a small register array but is still reset, so a
  // stale high cannot survive reset and look like a fresh step edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {dir_2, step_2, dir_1, step_1};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s_step = {sync_q[SYNC_STAGES-1][2], sync_q[SYNC_STAGES-1][0]};
  assign s_dir  = {sync_q[SYNC_STAGES-1][3], sync_q[SYNC_STAGES-1][1]};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    state_t          state, state_nxt;
    logic [QW-1:0]   qcnt, qcnt_nxt;
    logic            dir_lat, dir_lat_nxt;
    logic [DW-1:0]   dcnt;
    logic            dir_prev;
    logic            dir_chg;
    logic            evt_l, rise_viol;

    assign dir_chg = s_dir[ch] ^ dir_prev;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state    <= IDLE;
        qcnt     <= '0;
        dir_lat  <= 1'b0;
        dcnt     <= DW'(DIR_SETUP);
        dir_prev <= 1'b0;
      end else begin
        state    <= state_nxt;
        qcnt     <= qcnt_nxt;
        dir_lat  <= dir_lat_nxt;
        dir_prev <= s_dir[ch];
        if (dir_chg)                  dcnt <= '0;
        else if (dcnt < DW'(DIR_SETUP)) dcnt <= dcnt + DW'(1);
      end
    end

    // NOTE: every output of this block gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
      state_nxt   = state;
      qcnt_nxt    = qcnt;
      dir_lat_nxt = dir_lat;
      evt_l       = 1'b0;
      rise_viol   = 1'b0;
      unique case (state)
        IDLE: if (s_step[ch]) begin
          dir_lat_nxt = s_dir[ch];
          rise_viol   = dir_chg || (dcnt < DW'(DIR_SETUP));
          if (MIN_HIGH == 1) begin
            state_nxt = COUNTED;
            evt_l     = 1'b1;
          end else begin
            state_nxt = QUAL;
            qcnt_nxt  = QW'(1);
          end
        end
        QUAL: if (!s_step[ch]) begin
          state_nxt = IDLE;
        end else if (qcnt + QW'(1) == QW'(MIN_HIGH)) begin
          state_nxt = COUNTED;
          evt_l     = 1'b1;
        end else begin
          qcnt_nxt = qcnt + QW'(1);
        end
        COUNTED: if (!s_step[ch]) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    assign evt[ch]  = evt_l;
    // In the MIN_HIGH=1 case the count happens on the detection cycle, before dir is latched.
    assign neg[ch]  = (state == IDLE) ? s_dir[ch] : dir_lat;
    assign viol[ch] = rise_viol || (dir_chg && state != IDLE);
  end

  logic [31:0] pos_1_nxt, pos_2_nxt;

  always_comb begin
    pos_1_nxt = pos_1;
    pos_2_nxt = pos_2;
    if (evt[0]) pos_1_nxt = neg[0] ? pos_1 - 32'd1 : pos_1 + 32'd1;
    if (evt[1]) pos_2_nxt = neg[1] ? pos_2 - 32'd1 : pos_2 + 32'd1;
    if (clear) begin
      pos_1_nxt = '0;
      pos_2_nxt = '0;
    end
  end

  // X/Y are computed from the next motor values so they never lag pos_1/pos_2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_1      <= '0;
      pos_2      <= '0;
      pos_x      <= '0;
      pos_y      <= '0;
      step_evt_1 <= 1'b0;
      step_evt_2 <= 1'b0;
      dir_err    <= 1'b0;
    end else begin
      pos_1      <= pos_1_nxt;
      pos_2      <= pos_2_nxt;
      pos_x      <= {pos_1_nxt[31], pos_1_nxt} + {pos_2_nxt[31], pos_2_nxt};
      pos_y      <= {pos_1_nxt[31], pos_1_nxt} - {pos_2_nxt[31], pos_2_nxt};
      step_evt_1 <= evt[0];
      step_evt_2 <= evt[1];
      if (|viol)          dir_err <= 1'b1;
      else if (err_clear) dir_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stepdir_position_tracker.sv
// Directed bench for stepdir_position_tracker with default parameters
// (SYNC_STAGES=2, MIN_HIGH=2, DIR_SETUP=4): step latency is 3 edges after capture.
module tb_stepdir_position_tracker;

  logic        clk = 1'b0;
  logic        rst_n, step_1, dir_1, step_2, dir_2, clear, err_clear;
  logic [31:0] pos_1, pos_2;
  logic [32:0] pos_x, pos_y;
  logic        step_evt_1, step_evt_2, dir_err;

  int total = 0;
  int bad   = 0;
  int n_evt1 = 0;
  int n_evt2 = 0;

  stepdir_position_tracker dut (
    .clk(clk), .rst_n(rst_n),
    .step_1(step_1), .dir_1(dir_1), .step_2(step_2), .dir_2(dir_2),
    .clear(clear), .err_clear(err_clear),
    .pos_1(pos_1), .pos_2(pos_2), .pos_x(pos_x), .pos_y(pos_y),
    .step_evt_1(step_evt_1), .step_evt_2(step_evt_2), .dir_err(dir_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step_evt_1) n_evt1++;
    if (step_evt_2) n_evt2++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [1:0] ch, input int hi, input int lo);
    step_1 = ch[0];
    step_2 = ch[1];
    tick(hi);
    step_1 = 1'b0;
    step_2 = 1'b0;
    tick(lo);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; step_1 = 0; dir_1 = 0; step_2 = 0; dir_2 = 0; clear = 0; err_clear = 0;
    tick(2);
    check("reset_pos_1", {1'b0, pos_1}, 33'h0);
    check("reset_pos_x", pos_x, 33'h0);
    check("reset_dir_err", {32'h0, dir_err}, 33'h0);
    rst_n = 1'b1;
    tick(2);

    // 10 forward pulses on motor 1; first one also checks latency and strobe width
    n_evt1 = 0;
    step_1 = 1'b1;
    tick(3);
    check("lat_before", {1'b0, pos_1}, 33'h0);
    tick(1);
    check("lat_pos_1", {1'b0, pos_1}, 33'h1);
    check("lat_evt_hi", {32'h0, step_evt_1}, 33'h1);
    tick(1);
    check("lat_evt_lo", {32'h0, step_evt_1}, 33'h0);
    step_1 = 1'b0;
    tick(5);
    for (int i = 0; i < 9; i++) pulse(2'b01, 5, 5);
    check("t1_pos_1", {1'b0, pos_1}, 33'd10);
    check("t1_pos_2", {1'b0, pos_2}, 33'd0);
    check("t1_pos_x", pos_x, 33'd10);
    check("t1_pos_y", pos_y, 33'd10);
    check("t1_evt1_count", 33'(n_evt1), 33'd10);
    check("t1_dir_err", {32'h0, dir_err}, 33'h0);

    // Both motors, opposite directions
    dir_2 = 1'b1;
    tick(10);
    do_clear();
    check("clear_pos_x", pos_x, 33'h0);
    for (int i = 0; i < 7; i++) pulse(2'b11, 5, 5);
    check("t2_pos_1", {1'b0, pos_1}, 33'd7);
    check("t2_pos_2", {1'b0, pos_2}, 33'h0_FFFFFFF9);
    check("t2_pos_x", pos_x, 33'h0);
    check("t2_pos_y", pos_y, 33'd14);
    check("t2_dir_err", {32'h0, dir_err}, 33'h0);

    // Glitch rejection on motor 2
    dir_2 = 1'b0;
    tick(10);
    do_clear();
    n_evt2 = 0;
    pulse(2'b10, 1, 6);
    check("glitch_pos_2", {1'b0, pos_2}, 33'h0);
    check("glitch_evt2", 33'(n_evt2), 33'h0);
    pulse(2'b10, 3, 5);
    check("t3_pos_2", {1'b0, pos_2}, 33'd1);
    check("t3_evt2", 33'(n_evt2), 33'd1);

    // Reverse step wraps 0 -> 0xFFFFFFFF; X/Y sign extension
    dir_1 = 1'b1;
    tick(10);
    pulse(2'b01, 5, 5);
    check("wrap_pos_1", {1'b0, pos_1}, 33'h0_FFFFFFFF);
    check("wrap_pos_x", pos_x, 33'h0);
    check("wrap_pos_y", pos_y, 33'h1_FFFFFFFE);
    check("wrap_dir_err", {32'h0, dir_err}, 33'h0);

    // Dir toggled 2 cycles before step rise: flagged, step counted (wraps back to 0)
    dir_1 = 1'b0;
    tick(2);
    pulse(2'b01, 5, 5);
    check("setup_dir_err", {32'h0, dir_err}, 33'h1);
    check("setup_pos_1", {1'b0, pos_1}, 33'h0);
    check("setup_pos_y", pos_y, 33'h1_FFFFFFFF);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("err_clear", {32'h0, dir_err}, 33'h0);

    // Dir change while COUNTED, with err_clear exactly on the violation cycle
    step_1 = 1'b1;
    tick(5);
    dir_1 = 1'b1;
    tick(2);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("hold_viol_wins", {32'h0, dir_err}, 33'h1);
    step_1 = 1'b0;
    tick(5);
    check("hold_pos_1", {1'b0, pos_1}, 33'd1);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("err_clear_2", {32'h0, dir_err}, 33'h0);

    // clear on the step_evt_1 cycle: step dropped, strobe still pulses
    dir_1 = 1'b0;
    tick(10);
    step_1 = 1'b1;
    tick(3);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clr_evt1", {32'h0, step_evt_1}, 33'h1);
    check("clr_pos_1", {1'b0, pos_1}, 33'h0);
    check("clr_pos_2", {1'b0, pos_2}, 33'h0);
    check("clr_pos_y", pos_y, 33'h0);
    step_1 = 1'b0;
    tick(5);
    check("clr_dir_err", {32'h0, dir_err}, 33'h0);

    // Asynchronous reset mid-pulse; pulse still high at release counts once
    pulse(2'b10, 5, 5);
    check("pre_rst_pos_x", pos_x, 33'd1);
    step_1 = 1'b1;
    tick(2);
    rst_n = 1'b0;
    #1;
    check("rst_pos_2", {1'b0, pos_2}, 33'h0);
    check("rst_pos_x", pos_x, 33'h0);
    check("rst_pos_y", pos_y, 33'h0);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    step_1 = 1'b0;
    tick(5);
    check("post_rst_pos_1", {1'b0, pos_1}, 33'd1);
    check("post_rst_pos_x", pos_x, 33'd1);
    check("post_rst_dir_err", {32'h0, dir_err}, 33'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
